// File: rtl/data_block_fifo.sv
`default_nettype none
// =============================================================================
// data_block_fifo : packs DATA_W-bit words (first word in the MSBs) into
//   BLK_WORDS-word blocks and queues up to DEPTH_BLKS of them, show-ahead.
//   Optional sticky overflow/underflow flags: define DATA_BLOCK_FIFO_ERR_EN.
// Revision: 1.0
// =============================================================================
module data_block_fifo #(
  parameter int DATA_W     = 8,
  parameter int BLK_WORDS  = 16,
  parameter int DEPTH_BLKS = 4,
  localparam int BLK_W = DATA_W * BLK_WORDS,
  localparam int CNT_W = $clog2(DEPTH_BLKS + 1),
  localparam int IDX_W = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic              w_enable,
  input  logic [DATA_W-1:0] w_data,
  input  logic              pad,
  input  logic              r_enable,
  output logic [BLK_W-1:0]  r_block,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  blk_count,
  output logic [IDX_W-1:0]  word_idx,
  output logic              overflow,
  output logic              underflow
);

  localparam int PTR_W = (DEPTH_BLKS > 1) ? $clog2(DEPTH_BLKS) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH_BLKS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_WORDS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH_BLKS);

  logic [BLK_W-1:0] mem_q [DEPTH_BLKS];
  logic [BLK_W-1:0] mem_d [DEPTH_BLKS];
  logic [BLK_W-1:0] asm_q, asm_d, blk_w;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             empty_w, full_w, wr_acc, rd_acc, commit;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    empty_w = (cnt_q == '0);
    full_w  = (cnt_q == FULL_CNT);
    wr_acc  = w_enable && !full_w;
    rd_acc  = r_enable && !empty_w;

    // Unwritten slices of the assembly register are always zero, so blk_w
    // doubles as the zero-padded block on a pad commit.
    blk_w = asm_q;
    if (wr_acc) begin
      for (int i = 0; i < BLK_WORDS; i++) begin
        if (idx_q == IDX_W'(i)) blk_w[BLK_W-1-DATA_W*i -: DATA_W] = w_data;
      end
    end

    commit = (wr_acc && (idx_q == LAST_IDX)) ||
             (pad && !full_w && ((idx_q != '0) || wr_acc));

    mem_d    = mem_q;
    asm_d    = asm_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;

    if (clear) begin
      mem_d    = '{default: '0};
      asm_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      idx_d    = '0;
    end else begin
      if (commit) begin
        mem_d[wr_ptr_q] = blk_w;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
        asm_d           = '0;
        idx_d           = '0;
      end else if (wr_acc) begin
        asm_d = blk_w;
        idx_d = idx_q + 1'b1;
      end
      if (rd_acc) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({commit, rd_acc})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      mem_q    <= '{default: '0};
      asm_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      asm_q    <= asm_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
    end
  end

`ifdef DATA_BLOCK_FIFO_ERR_EN
  logic ovf_q, ovf_d, unf_q, unf_d;

  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (clear) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else begin
      if (w_enable && full_w)  ovf_d = 1'b1;
      if (r_enable && empty_w) unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign r_block   = mem_q[rd_ptr_q];
  assign empty     = empty_w;
  assign full      = full_w;
  assign blk_count = cnt_q;
  assign word_idx  = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_data_block_fifo.sv
`default_nettype none
// =============================================================================
// tb_data_block_fifo : directed scenarios plus randomized traffic against a
//   queue-based reference model of data_block_fifo (default parameters).
// Revision: 1.0
// =============================================================================
module tb_data_block_fifo;

`ifdef DATA_BLOCK_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         n_rst, clear, w_enable, pad, r_enable;
  logic [7:0]   w_data;
  logic [127:0] r_block;
  logic         empty, full, overflow, underflow;
  logic [2:0]   blk_count;
  logic [3:0]   word_idx;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: committed blocks and the words of the partial block.
  logic [127:0] m_blocks[$];
  logic [7:0]   m_part[$];
  bit           m_ovf, m_unf;

  data_block_fifo dut (
    .clk(clk), .n_rst(n_rst), .clear(clear), .w_enable(w_enable),
    .w_data(w_data), .pad(pad), .r_enable(r_enable), .r_block(r_block),
    .empty(empty), .full(full), .blk_count(blk_count), .word_idx(word_idx),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [127:0] pack_part();
    logic [127:0] b = '0;
    foreach (m_part[i]) b = {b[119:0], m_part[i]};
    return b << (8 * (16 - m_part.size()));
  endfunction

  // Advance the model by one clock edge using the inputs presented at that edge.
  task automatic model_edge();
    bit was_full, was_empty, wr;
    if (!n_rst || clear) begin
      m_blocks.delete();
      m_part.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      return;
    end
    was_full  = (m_blocks.size() == 4);
    was_empty = (m_blocks.size() == 0);
    wr = w_enable && !was_full;
    if (ERR_EN && w_enable && was_full)  m_ovf = 1'b1;
    if (ERR_EN && r_enable && was_empty) m_unf = 1'b1;
    if (r_enable && !was_empty) void'(m_blocks.pop_front());
    if (wr) m_part.push_back(w_data);
    if (m_part.size() == 16 || (pad && !was_full && m_part.size() > 0)) begin
      m_blocks.push_back(pack_part());
      m_part.delete();
    end
  endtask

  task automatic check_model();
    check("blk_count", blk_count, m_blocks.size());
    check("word_idx", word_idx, m_part.size());
    check("empty", empty, m_blocks.size() == 0);
    check("full", full, m_blocks.size() == 4);
    check("overflow", overflow, m_ovf);
    check("underflow", underflow, m_unf);
    if (m_blocks.size() != 0) check("r_block", r_block, m_blocks[0]);
  endtask

  task automatic step(input bit rst_n, input bit clr, input bit we,
                      input logic [7:0] wd, input bit pd, input bit re);
    n_rst = rst_n; clear = clr; w_enable = we; w_data = wd; pad = pd; r_enable = re;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic wr_bytes(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) step(1, 0, 1, base + 8'(i), 0, 0);
  endtask

  task automatic do_clear();
    step(1, 1, 0, 8'h00, 0, 0);
  endtask

  initial begin
    n_rst = 1'b0; clear = 1'b0; w_enable = 1'b0; w_data = '0; pad = 1'b0; r_enable = 1'b0;
    step(0, 0, 0, 8'h00, 0, 0);
    step(0, 0, 1, 8'h55, 1, 1);
    check("rst_rblock", r_block, '0);
    check("rst_empty", empty, 1'b1);

    // 16 ascending bytes form one block.
    wr_bytes(8'h00, 15);
    check("t1_empty_before", empty, 1'b1);
    wr_bytes(8'h0F, 1);
    check("t1_rblock", r_block, 128'h000102030405060708090a0b0c0d0e0f);
    check("t1_cnt", blk_count, 3'd1);

    // Partial block committed with zero padding.
    do_clear();
    wr_bytes(8'hA1, 5);
    step(1, 0, 0, 8'h00, 1, 0);
    check("t2_rblock", r_block, {40'hA1A2A3A4A5, 88'h0});
    check("t2_idx", word_idx, 4'd0);
    step(1, 0, 0, 8'h00, 1, 0);
    check("t2_pad_noop_cnt", blk_count, 3'd1);

    // Full FIFO drops the write.
    do_clear();
    wr_bytes(8'h40, 64);
    step(1, 0, 1, 8'hFF, 0, 0);
    check("t3_full", full, 1'b1);
    check("t3_idx", word_idx, 4'd0);
    check("t3_ovf", overflow, ERR_EN);
    step(1, 0, 1, 8'hEE, 0, 1);
    check("t3_drop_with_read", word_idx, 4'd0);

    // Commit and read on the same edge.
    do_clear();
    wr_bytes(8'h10, 16);
    wr_bytes(8'h20, 16);
    wr_bytes(8'h30, 15);
    step(1, 0, 1, 8'h3F, 0, 1);
    check("t4_cnt", blk_count, 3'd2);
    check("t4_rblock", r_block, 128'h202122232425262728292a2b2c2d2e2f);

    // Read while empty.
    do_clear();
    step(1, 0, 0, 8'h00, 0, 1);
    check("t5_unf", underflow, ERR_EN);
    check("t5_empty", empty, 1'b1);
    do_clear();
    check("t5_unf_clr", underflow, 1'b0);

    // Clear mid-block.
    wr_bytes(8'h60, 55);
    check("t6_idx_pre", word_idx, 4'd7);
    do_clear();
    check("t6_cnt", blk_count, 3'd0);
    check("t6_idx", word_idx, 4'd0);
    wr_bytes(8'h50, 16);
    check("t6_cnt_new", blk_count, 3'd1);
    check("t6_rblock", r_block, 128'h505152535455565758595a5b5c5d5e5f);
    step(1, 0, 0, 8'h00, 0, 1);
    check("t6_empty_after", empty, 1'b1);

    // Randomized traffic; read pressure alternates to reach both full and empty.
    for (int c = 0; c < 4000; c++) begin
      int rd_pct;
      rd_pct = ((c / 250) % 2 != 0) ? 12 : 55;
      step(($urandom_range(0, 999) != 0),
           ($urandom_range(0, 299) == 0),
           ($urandom_range(0, 99) < 75),
           8'($urandom),
           ($urandom_range(0, 99) < 6),
           ($urandom_range(0, 99) < rd_pct));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
